// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one-deep IR fed over a req/gnt/rvalid memory port.
// Optional misaligned-fetch trap enabled by IFETCH_ALIGN_CHECK_EN.
module ifetch_unit #(
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        w_pc,
  output logic [31:0] in_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
`ifdef IFETCH_ALIGN_CHECK_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        mis_q, mis_d;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= IR_RESET;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    mis_d      = mis_q;
    w_pc       = 1'b0;
    in_pc      = pc;
    imem_req   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        if (pc[1:0] != 2'b00) begin
          mis_d   = 1'b1;
          state_d = S_FAULT;
        end else
`endif
        begin
          imem_req = 1'b1;
          if (imem_gnt) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          w_pc       = 1'b1;
          in_pc      = pc + PC_STEP;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = state_q;
    endcase

    // Redirect overrides anything the state decode did, including a capture.
    if (redirect && state_q != S_IDLE) begin
      w_pc       = 1'b1;
      in_pc      = redirect_target;
      ir_d       = IR_RESET;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = 1'b0;
      mis_d      = 1'b0;
      case (state_q)
        S_REQ:   state_d = (imem_req && imem_gnt) ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign fetch_misalign = mis_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: cycle table plus hand-written
// mid-transaction reset and misaligned-fetch sequences.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        w_pc;
  logic [31:0] in_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_misalign;

  int total = 0;
  int bad   = 0;

  ifetch_unit dut (
    .CLK(CLK), .reset(reset), .pc(pc),
    .w_pc(w_pc), .in_pc(in_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redirect(redirect),
    .redirect_target(redirect_target),
    .fetch_misalign(fetch_misalign)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        req;
    logic        wpc;
    logic [31:0] inpc;
    logic        irv;
    logic [31:0] ir;
    logic [31:0] irpc;
  } vec_t;

  localparam int N = 30;
  vec_t tbl [N];

  function automatic vec_t mk(
    input logic [31:0] p, input logic g, input logic v,
    input logic [31:0] d, input logic r, input logic rd,
    input logic [31:0] t, input logic eq, input logic ew,
    input logic [31:0] ei, input logic ev,
    input logic [31:0] eir, input logic [31:0] eip);
    vec_t x;
    x.pc = p; x.gnt = g; x.rv = v; x.rdata = d;
    x.rdy = r; x.redir = rd; x.tgt = t;
    x.req = eq; x.wpc = ew; x.inpc = ei;
    x.irv = ev; x.ir = eir; x.irpc = eip;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] p, input logic g,
                     input logic v, input logic [31:0] d,
                     input logic r, input logic rd,
                     input logic [31:0] t);
    pc = p; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    ir_ready = r; redirect = rd; redirect_target = t;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(32'h0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[2]  = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    tbl[3]  = mk(32'h0, 0, 1, 32'h2008_0005, 1, 0, 0,
                 0, 1, 32'h4, 0, 32'h0, 32'h0);
    tbl[4]  = mk(32'h4, 0, 0, 0, 1, 0, 0,
                 0, 0, 32'h4, 1, 32'h2008_0005, 32'h0);
    tbl[5]  = mk(32'h4, 0, 0, 0, 0, 0, 0,
                 1, 0, 32'h4, 0, 32'h2008_0005, 32'h0);
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = mk(32'h4, 1, 0, 0, 0, 0, 0,
                 1, 0, 32'h4, 0, 32'h2008_0005, 32'h0);
    tbl[9]  = mk(32'h4, 0, 1, 32'hAAAA_0001, 0, 0, 0,
                 0, 1, 32'h8, 0, 32'h2008_0005, 32'h0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(32'h8, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'h8, 1, 32'hAAAA_0001, 32'h4);
    tbl[15] = mk(32'h8, 0, 0, 0, 1, 0, 0,
                 0, 0, 32'h8, 1, 32'hAAAA_0001, 32'h4);
    tbl[16] = mk(32'h8, 1, 0, 0, 0, 0, 0,
                 1, 0, 32'h8, 0, 32'hAAAA_0001, 32'h4);
    tbl[17] = mk(32'h8, 0, 0, 0, 0, 1, 32'h40,
                 0, 1, 32'h40, 0, 32'hAAAA_0001, 32'h4);
    tbl[18] = mk(32'h40, 0, 0, 0, 0, 0, 0,
                 0, 0, 32'h40, 0, 32'h0, 32'h4);
    tbl[19] = mk(32'h40, 0, 1, 32'hDEAD_BEEF, 0, 0, 0,
                 0, 0, 32'h40, 0, 32'h0, 32'h4);
    tbl[20] = mk(32'h40, 1, 0, 0, 0, 0, 0,
                 1, 0, 32'h40, 0, 32'h0, 32'h4);
    tbl[21] = mk(32'h40, 0, 1, 32'h1234_5678, 0, 1, 32'hFFFF_FFFC,
                 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h4);
    tbl[22] = mk(32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0,
                 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h4);
    tbl[23] = mk(32'hFFFF_FFFC, 0, 1, 32'h0BAD_F00D, 0, 0, 0,
                 0, 1, 32'h0, 0, 32'h0, 32'h4);
    tbl[24] = mk(32'h0, 0, 0, 0, 0, 1, 32'h100,
                 0, 1, 32'h100, 1, 32'h0BAD_F00D, 32'hFFFF_FFFC);
    tbl[25] = mk(32'h100, 0, 0, 0, 0, 0, 0,
                 1, 0, 32'h100, 0, 32'h0, 32'hFFFF_FFFC);
    tbl[26] = mk(32'h100, 1, 0, 0, 0, 1, 32'h200,
                 1, 1, 32'h200, 0, 32'h0, 32'hFFFF_FFFC);
    tbl[27] = mk(32'h200, 0, 0, 0, 0, 1, 32'h300,
                 0, 1, 32'h300, 0, 32'h0, 32'hFFFF_FFFC);
    tbl[28] = mk(32'h300, 0, 1, 32'h55, 0, 0, 0,
                 0, 0, 32'h300, 0, 32'h0, 32'hFFFF_FFFC);
    tbl[29] = mk(32'h300, 0, 0, 0, 0, 0, 0,
                 1, 0, 32'h300, 0, 32'h0, 32'hFFFF_FFFC);

    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      drv(tbl[i].pc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata,
          tbl[i].rdy, tbl[i].redir, tbl[i].tgt);
      #3;
      chk($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("v%0d.addr", i), imem_addr, tbl[i].pc);
      chk($sformatf("v%0d.w_pc", i), {31'd0, w_pc}, {31'd0, tbl[i].wpc});
      chk($sformatf("v%0d.in_pc", i), in_pc, tbl[i].inpc);
      chk($sformatf("v%0d.ir_valid", i), {31'd0, ir_valid},
          {31'd0, tbl[i].irv});
      chk($sformatf("v%0d.ir", i), ir, tbl[i].ir);
      chk($sformatf("v%0d.ir_pc", i), ir_pc, tbl[i].irpc);
      chk($sformatf("v%0d.misalign", i), {31'd0, fetch_misalign}, 32'd0);
      tick();
    end

    // Reset while a read is outstanding; the late rvalid must be ignored.
    drv(32'h300, 1, 0, 0, 0, 0, 0);
    tick();
    drv(32'h300, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst.ir_pc", ir_pc, 32'h0);
    tick();
    reset = 1'b0;
    drv(32'h300, 0, 1, 32'h77, 0, 0, 0);
    #3;
    chk("rst.idle_req", {31'd0, imem_req}, 32'd0);
    chk("rst.idle_wpc", {31'd0, w_pc}, 32'd0);
    tick();
    #3;
    chk("rst.req_again", {31'd0, imem_req}, 32'd1);
    chk("rst.req_wpc", {31'd0, w_pc}, 32'd0);
    tick();
    drv(32'h300, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst.ir", ir, 32'h0);
    chk("rst.ir_valid2", {31'd0, ir_valid}, 32'd0);

`ifdef IFETCH_ALIGN_CHECK_EN
    drv(32'h300, 0, 0, 0, 0, 1, 32'h6);
    #1;
    chk("al.redir_wpc", {31'd0, w_pc}, 32'd1);
    chk("al.redir_in", in_pc, 32'h6);
    tick();
    drv(32'h6, 0, 0, 0, 0, 0, 0);
    #3;
    chk("al.noreq", {31'd0, imem_req}, 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drv(32'h6, 1, 0, 0, 0, 0, 0);
      #3;
      chk("al.fault_req", {31'd0, imem_req}, 32'd0);
      chk("al.fault_mis", {31'd0, fetch_misalign}, 32'd1);
      chk("al.fault_wpc", {31'd0, w_pc}, 32'd0);
      tick();
    end
    drv(32'h6, 0, 0, 0, 0, 1, 32'h8);
    #3;
    chk("al.fix_wpc", {31'd0, w_pc}, 32'd1);
    chk("al.fix_in", in_pc, 32'h8);
    chk("al.fix_mis", {31'd0, fetch_misalign}, 32'd1);
    tick();
    drv(32'h8, 0, 0, 0, 0, 0, 0);
    #3;
    chk("al.req8", {31'd0, imem_req}, 32'd1);
    chk("al.addr8", imem_addr, 32'h8);
    chk("al.mis_clr", {31'd0, fetch_misalign}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
